// File: rtl/time_ctrl_pkg.sv
// Shared encodings and default timing constants
// for the time-setting controller and display.
package time_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam int HOLD_CYCLES_DEF   = 500;
  localparam int REPEAT_CYCLES_DEF = 100;
  localparam int TIMEOUT_TICKS_DEF = 30;
  localparam int CNT_W_DEF         = 16;

endpackage

// File: rtl/key_repeat.sv
// Rising-edge detector with hold-then-repeat
// auto-repeat; pulse is a same-cycle strobe.
module key_repeat
  import time_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clr,
  output logic pulse
);

  logic             prev_q;
  logic             act_q, act_d;
  logic             rep_q, rep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim;
  logic             edge_w;

  assign edge_w = btn & ~prev_q;
  assign lim    = rep_q ? CNT_W'(REPEAT_CYCLES)
                        : CNT_W'(HOLD_CYCLES);

  // act_q stays low after a clear until a fresh press
  always_comb begin
    pulse = 1'b0;
    act_d = act_q;
    rep_d = rep_q;
    cnt_d = cnt_q;
    if (clr || !btn) begin
      act_d = 1'b0;
      rep_d = 1'b0;
      cnt_d = '0;
    end else if (edge_w) begin
      pulse = 1'b1;
      act_d = 1'b1;
      rep_d = 1'b0;
      cnt_d = CNT_W'(1);
    end else if (act_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == lim) begin
        pulse = 1'b1;
        rep_d = 1'b1;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
      act_q  <= 1'b0;
      rep_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= btn;
      act_q  <= act_d;
      rep_q  <= rep_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Mode FSM turning tick and buttons into registered
// command pulses and blink flags for the time counter.
module time_set_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_fmt,
  output logic              sec_en,
  output logic              sec_clr,
  output logic              min_inc,
  output logic              hour_inc,
  output logic              toggle,
  output logic              blink_hour,
  output logic              blink_min,
  output logic [MODE_W-1:0] mode
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  mode_e           state_q, state_d;
  logic            mprev_q, fprev_q;
  logic            phase_q, phase_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            sec_en_q, sec_clr_q, min_q, hour_q;
  logic            tog_q, bh_q, bm_q;
  logic            mode_edge, fmt_edge;
  logic            in_set, inc_clr, inc_pulse;
  logic            clear_evt, to_hit;

  assign mode_edge = btn_mode & ~mprev_q;
  assign fmt_edge  = btn_fmt & ~fprev_q;
  assign in_set    = (state_q != MODE_RUN);
  // a mode edge swallows any same-cycle increment
  assign inc_clr   = !in_set || mode_edge;
  assign clear_evt = mode_edge | fmt_edge | inc_pulse;
  assign to_hit    = in_set && tick_1hz && !clear_evt &&
                     (to_q == TO_W'(TIMEOUT_TICKS - 1));

  key_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CNT_W        (CNT_W)
  ) u_inc (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_inc),
    .clr  (inc_clr),
    .pulse(inc_pulse)
  );

  always_comb begin
    state_d = state_q;
    if (mode_edge) begin
      unique case (state_q)
        MODE_RUN:      state_d = MODE_SET_HOUR;
        MODE_SET_HOUR: state_d = MODE_SET_MIN;
        default:       state_d = MODE_RUN;
      endcase
    end else if (to_hit) begin
      state_d = MODE_RUN;
    end
  end

  always_comb begin
    to_d = to_q;
    if (!in_set || clear_evt || state_d != state_q)
      to_d = '0;
    else if (tick_1hz)
      to_d = to_q + TO_W'(1);
  end

  always_comb begin
    phase_d = phase_q;
    if (state_d != MODE_RUN && state_d != state_q)
      phase_d = 1'b1;
    else if (tick_1hz)
      phase_d = ~phase_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MODE_RUN;
      mprev_q   <= 1'b1;
      fprev_q   <= 1'b1;
      phase_q   <= 1'b1;
      to_q      <= '0;
      sec_en_q  <= 1'b0;
      sec_clr_q <= 1'b0;
      min_q     <= 1'b0;
      hour_q    <= 1'b0;
      tog_q     <= 1'b0;
      bh_q      <= 1'b0;
      bm_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mprev_q   <= btn_mode;
      fprev_q   <= btn_fmt;
      phase_q   <= phase_d;
      to_q      <= to_d;
      sec_en_q  <= !in_set && tick_1hz;
      sec_clr_q <= !in_set && mode_edge;
      min_q     <= inc_pulse &&
                   (state_q == MODE_SET_MIN);
      hour_q    <= inc_pulse &&
                   (state_q == MODE_SET_HOUR);
      tog_q     <= fmt_edge;
      bh_q      <= phase_d &&
                   (state_d == MODE_SET_HOUR);
      bm_q      <= phase_d &&
                   (state_d == MODE_SET_MIN);
    end
  end

  assign sec_en     = sec_en_q;
  assign sec_clr    = sec_clr_q;
  assign min_inc    = min_q;
  assign hour_inc   = hour_q;
  assign toggle     = tog_q;
  assign blink_hour = bh_q;
  assign blink_min  = bm_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: per-cycle expected
// output vectors queued with stimulus, checked next cycle.
module tb_time_set_ctrl;

  logic       clk;
  logic       reset;
  logic       tick_1hz, btn_mode, btn_inc, btn_fmt;
  logic       sec_en, sec_clr, min_inc, hour_inc, toggle;
  logic       blink_hour, blink_min;
  logic [1:0] mode;

  int n_cmp;
  int n_bad;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  time_set_ctrl #(
    .HOLD_CYCLES  (4),
    .REPEAT_CYCLES(2),
    .TIMEOUT_TICKS(3),
    .CNT_W        (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_fmt   (btn_fmt),
    .sec_en    (sec_en),
    .sec_clr   (sec_clr),
    .min_inc   (min_inc),
    .hour_inc  (hour_inc),
    .toggle    (toggle),
    .blink_hour(blink_hour),
    .blink_min (blink_min),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  // {sec_en,sec_clr,min_inc,hour_inc,toggle,blink_hour,blink_min,mode}
  function automatic logic [8:0] E(
    input bit se, input bit sc, input bit mi, input bit hi,
    input bit tg, input bit bh, input bit bm, input bit [1:0] md);
    return {se, sc, mi, hi, tg, bh, bm, md};
  endfunction

  task automatic check();
    logic [8:0] obs;
    logic [8:0] ex;
    string      t;
    if (exp_q.size() > 0) begin
      ex  = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {sec_en, sec_clr, min_inc, hour_inc, toggle,
             blink_hour, blink_min, mode};
      n_cmp++;
      assert (obs === ex) else begin
        n_bad++;
        $error("FAIL %s observed=%b expected=%b", t, obs, ex);
      end
    end
  endtask

  task automatic step(input string tag, input logic r,
                      input logic m, input logic i,
                      input logic f, input logic t,
                      input logic [8:0] ex);
    @(negedge clk);
    check();
    reset    = r;
    btn_mode = m;
    btn_inc  = i;
    btn_fmt  = f;
    tick_1hz = t;
    exp_q.push_back(ex);
    tag_q.push_back(tag);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    clk      = 1'b0;
    reset    = 1'b1;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_fmt  = 1'b0;

    step("rst0", 1, 0, 0, 0, 0, E(0,0,0,0,0,0,0,0));
    step("rst1", 1, 0, 0, 0, 0, E(0,0,0,0,0,0,0,0));

    // 1: ticks in RUN
    for (int k = 0; k < 5; k++) begin
      step("t1_tick", 0, 0, 0, 0, 1, E(1,0,0,0,0,0,0,0));
      step("t1_idle", 0, 0, 0, 0, 0, E(0,0,0,0,0,0,0,0));
    end

    // 2: mode cycle with single increments
    step("t2_mode1", 0, 1, 0, 0, 0, E(0,1,0,0,0,1,0,1));
    step("t2_rel1",  0, 0, 0, 0, 0, E(0,0,0,0,0,1,0,1));
    step("t2_inc_h", 0, 0, 1, 0, 0, E(0,0,0,1,0,1,0,1));
    step("t2_irel1", 0, 0, 0, 0, 0, E(0,0,0,0,0,1,0,1));
    step("t2_mode2", 0, 1, 0, 0, 0, E(0,0,0,0,0,0,1,2));
    step("t2_rel2",  0, 0, 0, 0, 0, E(0,0,0,0,0,0,1,2));
    step("t2_inc_m", 0, 0, 1, 0, 0, E(0,0,1,0,0,0,1,2));
    step("t2_irel2", 0, 0, 0, 0, 0, E(0,0,0,0,0,0,1,2));
    step("t2_mode3", 0, 1, 0, 0, 0, E(0,0,0,0,0,0,0,0));
    step("t2_rel3",  0, 0, 0, 0, 0, E(0,0,0,0,0,0,0,0));

    // 3: hold-and-repeat in SET_MIN
    step("t3_mode1", 0, 1, 0, 0, 0, E(0,1,0,0,0,1,0,1));
    step("t3_rel1",  0, 0, 0, 0, 0, E(0,0,0,0,0,1,0,1));
    step("t3_mode2", 0, 1, 0, 0, 0, E(0,0,0,0,0,0,1,2));
    step("t3_rel2",  0, 0, 0, 0, 0, E(0,0,0,0,0,0,1,2));
    for (int k = 0; k < 10; k++)
      step("t3_hold", 0, 0, 1, 0, 0,
           E(0,0,(k==0||k==3||k==5||k==7||k==9),0,0,0,1,2));
    for (int k = 0; k < 3; k++)
      step("t3_after", 0, 0, 0, 0, 0, E(0,0,0,0,0,0,1,2));
    step("t3_mode3", 0, 1, 0, 0, 0, E(0,0,0,0,0,0,0,0));
    step("t3_rel3",  0, 0, 0, 0, 0, E(0,0,0,0,0,0,0,0));

    // 4a: timeout after three ticks
    step("t4_mode",  0, 1, 0, 0, 0, E(0,1,0,0,0,1,0,1));
    step("t4_rel",   0, 0, 0, 0, 0, E(0,0,0,0,0,1,0,1));
    step("t4_tick1", 0, 0, 0, 0, 1, E(0,0,0,0,0,0,0,1));
    step("t4_idle1", 0, 0, 0, 0, 0, E(0,0,0,0,0,0,0,1));
    step("t4_tick2", 0, 0, 0, 0, 1, E(0,0,0,0,0,1,0,1));
    step("t4_idle2", 0, 0, 0, 0, 0, E(0,0,0,0,0,1,0,1));
    step("t4_tick3", 0, 0, 0, 0, 1, E(0,0,0,0,0,0,0,0));
    step("t4_idle3", 0, 0, 0, 0, 0, E(0,0,0,0,0,0,0,0));

    // 4b: inc press restarts the timeout count
    step("t4b_mode",  0, 1, 0, 0, 0, E(0,1,0,0,0,1,0,1));
    step("t4b_rel",   0, 0, 0, 0, 0, E(0,0,0,0,0,1,0,1));
    step("t4b_tick1", 0, 0, 0, 0, 1, E(0,0,0,0,0,0,0,1));
    step("t4b_idle1", 0, 0, 0, 0, 0, E(0,0,0,0,0,0,0,1));
    step("t4b_tick2", 0, 0, 0, 0, 1, E(0,0,0,0,0,1,0,1));
    step("t4b_idle2", 0, 0, 0, 0, 0, E(0,0,0,0,0,1,0,1));
    step("t4b_inc",   0, 0, 1, 0, 0, E(0,0,0,1,0,1,0,1));
    step("t4b_irel",  0, 0, 0, 0, 0, E(0,0,0,0,0,1,0,1));
    step("t4b_tick3", 0, 0, 0, 0, 1, E(0,0,0,0,0,0,0,1));
    step("t4b_idle3", 0, 0, 0, 0, 0, E(0,0,0,0,0,0,0,1));
    step("t4b_tick4", 0, 0, 0, 0, 1, E(0,0,0,0,0,1,0,1));
    step("t4b_idle4", 0, 0, 0, 0, 0, E(0,0,0,0,0,1,0,1));
    step("t4b_tick5", 0, 0, 0, 0, 1, E(0,0,0,0,0,0,0,0));
    step("t4b_idle5", 0, 0, 0, 0, 0, E(0,0,0,0,0,0,0,0));

    // 5: simultaneous mode+inc, then fmt in SET_MIN
    step("t5_mode",   0, 1, 0, 0, 0, E(0,1,0,0,0,1,0,1));
    step("t5_rel",    0, 0, 0, 0, 0, E(0,0,0,0,0,1,0,1));
    step("t5_m_and_i",0, 1, 1, 0, 0, E(0,0,0,0,0,0,1,2));
    step("t5_rel2",   0, 0, 0, 0, 0, E(0,0,0,0,0,0,1,2));
    step("t5_fmt",    0, 0, 0, 1, 0, E(0,0,0,0,1,0,1,2));
    step("t5_frel",   0, 0, 0, 0, 0, E(0,0,0,0,0,0,1,2));

    // 6: reset in the middle of auto-repeat
    for (int k = 0; k < 5; k++)
      step("t6_hold", 0, 0, 1, 0, 0,
           E(0,0,(k==0||k==3),0,0,0,1,2));
    step("t6_rst0", 1, 0, 1, 0, 0, E(0,0,0,0,0,0,0,0));
    step("t6_rst1", 1, 0, 1, 0, 0, E(0,0,0,0,0,0,0,0));
    for (int k = 0; k < 6; k++)
      step("t6_post", 0, 0, 1, 0, 0, E(0,0,0,0,0,0,0,0));
    step("t6_irel",   0, 0, 0, 0, 0, E(0,0,0,0,0,0,0,0));
    step("t6_fmtrun", 0, 0, 0, 1, 0, E(0,0,0,0,1,0,0,0));
    step("t6_frel",   0, 0, 0, 0, 0, E(0,0,0,0,0,0,0,0));

    @(negedge clk);
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
